// File: rtl/pe_instr_fetch.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pe_instr_fetch : prefetching fetch stage that feeds the PE decoder.       |
// | Optional starvation counter via PE_INSTR_FETCH_PERF_CNT_EN.  Rev 1.0      |
// +---------------------------------------------------------------------------+
module pe_instr_fetch #(
   parameter int                  INSTR_L     = 32,
   parameter int                  OPCODE_L    = 4,
   parameter logic [OPCODE_L-1:0] HALT_OPCODE = 4'hF,
   parameter int                  IMEM_ADDR_L = 9,
   parameter int                  FIFO_DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [IMEM_ADDR_L-1:0] start_addr,
   output logic                   busy,
   output logic                   done,
   output logic                   mem_rd_en,
   output logic [IMEM_ADDR_L-1:0] mem_rd_addr,
   input  logic [INSTR_L-1:0]     mem_rd_data,
   output logic                   instr_vld,
   output logic [INSTR_L-1:0]     instr,
   input  logic                   instr_rdy
`ifdef PE_INSTR_FETCH_PERF_CNT_EN
   ,
   output logic [31:0]            stall_cnt
`endif
);

   localparam int PTR_L = $clog2(FIFO_DEPTH);
   localparam int CNT_L = PTR_L + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [IMEM_ADDR_L-1:0] pc_q, pc_d;
   logic                   halt_seen_q, halt_seen_d;
   logic                   inflight_q;
   logic [PTR_L-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_L-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_L-1:0]       count_q, count_d;
   logic [INSTR_L-1:0]     mem_q [FIFO_DEPTH];
   logic [INSTR_L-1:0]     mem_d [FIFO_DEPTH];

   logic                   pop;
   logic                   push;
   logic                   rsp_halt;
   logic [CNT_L:0]         occ_sum;
   logic [CNT_L:0]         occ_lim;
   logic                   can_issue;

   assign instr_vld   = (count_q != '0);
   assign instr       = instr_vld ? mem_q[rd_ptr_q] : '0;
   assign busy        = (state_q != ST_IDLE);
   assign mem_rd_addr = pc_q;
   assign pop         = instr_vld && instr_rdy;

   // Responses are only meaningful for reads issued before HALT came back.
   assign rsp_halt = inflight_q && !halt_seen_q
                     && (mem_rd_data[OPCODE_L-1:0] == HALT_OPCODE);
   assign push     = inflight_q && !halt_seen_q && !rsp_halt;

   // Credit: queued + in-flight, minus this cycle's pop, must leave a free slot.
   assign occ_sum   = {1'b0, count_q} + (CNT_L+1)'(inflight_q);
   assign occ_lim   = (CNT_L+1)'(FIFO_DEPTH) + (CNT_L+1)'(pop);
   assign can_issue = (occ_sum < occ_lim);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      halt_seen_d = halt_seen_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q + CNT_L'(push) - CNT_L'(pop);
      mem_d       = mem_q;
      mem_rd_en   = 1'b0;
      done        = 1'b0;

      if (push) begin
         mem_d[wr_ptr_q] = mem_rd_data;
         wr_ptr_d        = wr_ptr_q + PTR_L'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_L'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_FETCH;
               pc_d        = start_addr;
               halt_seen_d = 1'b0;
               wr_ptr_d    = '0;
               rd_ptr_d    = '0;
               count_d     = '0;
            end
         end
         ST_FETCH: begin
            if (!halt_seen_q && can_issue) begin
               mem_rd_en = 1'b1;
               pc_d      = pc_q + IMEM_ADDR_L'(1);
            end
            if (rsp_halt) begin
               halt_seen_d = 1'b1;
               state_d     = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // The last outstanding read returns this cycle and is discarded.
            if (count_q == '0) begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pc_q        <= '0;
         halt_seen_q <= 1'b0;
         inflight_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         halt_seen_q <= halt_seen_d;
         inflight_q  <= mem_rd_en;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         mem_q       <= mem_d;
      end
   end

`ifdef PE_INSTR_FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   assign stall_cnt = stall_cnt_q;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (state_q == ST_IDLE && start) begin
         stall_cnt_d = '0;
      end else if (state_q == ST_FETCH && !instr_vld && stall_cnt_q != '1) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end
`endif

endmodule

`default_nettype wire
